// File: rtl/grid_feeder.sv
// Board streaming front end: buffers a 64-square board from the host, streams it plus a
// move word to the decoder, then absorbs the updated board coming back.
module grid_feeder #(
    parameter int MOVE_WIDTH     = 16,
    parameter int GRID_ELE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      load_v,
    input  logic [GRID_ELE_WIDTH-1:0] load_d,
    input  logic                      start,
    input  logic [MOVE_WIDTH-1:0]     move_d,
    input  logic                      ret_v,
    input  logic [GRID_ELE_WIDTH-1:0] ret_d,
    output logic                      grid_ov,
    output logic [GRID_ELE_WIDTH-1:0] grid_od,
    output logic                      move_ov,
    output logic [MOVE_WIDTH-1:0]     move_od,
    output logic                      busy,
    output logic                      board_valid,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND_GRID = 3'd2,
        SEND_MOVE = 3'd3,
        RECV      = 3'd4
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'd63;

    state_t                    state_r, state_n;
    logic [5:0]                cnt_r, cnt_n;
    logic                      board_valid_r, board_valid_n;
    logic [MOVE_WIDTH-1:0]     move_r, move_n;
    logic [GRID_ELE_WIDTH-1:0] board_r [0:63];

    logic                      wr_en_s;
    logic [5:0]                wr_addr_s;
    logic [GRID_ELE_WIDTH-1:0] wr_data_s;

    logic                      grid_ov_r, grid_ov_n;
    logic [GRID_ELE_WIDTH-1:0] grid_od_r, grid_od_n;
    logic                      move_ov_r, move_ov_n;
    logic [MOVE_WIDTH-1:0]     move_od_r, move_od_n;
    logic                      busy_r, busy_n;
    logic                      done_r, done_n;
    logic                      err_r, err_n;

    // Next-state, counter, buffer-write and next-output decode.
    always_comb begin
        state_n       = state_r;
        cnt_n         = cnt_r;
        board_valid_n = board_valid_r;
        move_n        = move_r;
        wr_en_s       = 1'b0;
        wr_addr_s     = cnt_r;
        wr_data_s     = load_d;
        grid_ov_n     = 1'b0;
        grid_od_n     = {GRID_ELE_WIDTH{1'b0}};
        move_ov_n     = 1'b0;
        move_od_n     = {MOVE_WIDTH{1'b0}};
        done_n        = 1'b0;
        err_n         = 1'b0;
        case (state_r)
            IDLE: begin
                // A load always beats a simultaneous start.
                if (load_v) begin
                    wr_en_s       = 1'b1;
                    wr_addr_s     = 6'd0;
                    cnt_n         = 6'd1;
                    board_valid_n = 1'b0;
                    state_n       = LOAD;
                end else if (start) begin
                    if (board_valid_r) begin
                        move_n  = move_d;
                        cnt_n   = 6'd0;
                        state_n = SEND_GRID;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD: begin
                if (load_v) begin
                    wr_en_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        board_valid_n = 1'b1;
                        cnt_n         = 6'd0;
                        state_n       = IDLE;
                    end else begin
                        cnt_n = cnt_r + 6'd1;
                    end
                end else begin
                    state_n = LOAD;
                end
            end
            SEND_GRID: begin
                grid_ov_n = 1'b1;
                grid_od_n = board_r[cnt_r];
                if (cnt_r == LAST_IDX) begin
                    cnt_n   = 6'd0;
                    state_n = SEND_MOVE;
                end else begin
                    cnt_n = cnt_r + 6'd1;
                end
            end
            SEND_MOVE: begin
                move_ov_n = 1'b1;
                move_od_n = move_r;
                cnt_n     = 6'd0;
                state_n   = RECV;
            end
            RECV: begin
                if (ret_v) begin
                    wr_en_s   = 1'b1;
                    wr_data_s = ret_d;
                    if (cnt_r == LAST_IDX) begin
                        done_n        = 1'b1;
                        board_valid_n = 1'b1;
                        cnt_n         = 6'd0;
                        state_n       = IDLE;
                    end else begin
                        cnt_n = cnt_r + 6'd1;
                    end
                end else begin
                    state_n = RECV;
                end
            end
            default: begin
                state_n       = IDLE;
                cnt_n         = 6'd0;
                board_valid_n = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath and output registers; reset clears every visible output at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r         <= 6'd0;
            board_valid_r <= 1'b0;
            move_r        <= {MOVE_WIDTH{1'b0}};
            grid_ov_r     <= 1'b0;
            grid_od_r     <= {GRID_ELE_WIDTH{1'b0}};
            move_ov_r     <= 1'b0;
            move_od_r     <= {MOVE_WIDTH{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            cnt_r         <= cnt_n;
            board_valid_r <= board_valid_n;
            move_r        <= move_n;
            grid_ov_r     <= grid_ov_n;
            grid_od_r     <= grid_od_n;
            move_ov_r     <= move_ov_n;
            move_od_r     <= move_od_n;
            busy_r        <= busy_n;
            done_r        <= done_n;
            err_r         <= err_n;
        end
    end

    // Board storage is left unreset; board_valid qualifies its contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            board_r[wr_addr_s] <= wr_data_s;
        end
    end

    assign grid_ov     = grid_ov_r;
    assign grid_od     = grid_od_r;
    assign move_ov     = move_ov_r;
    assign move_od     = move_od_r;
    assign busy        = busy_r;
    assign board_valid = board_valid_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_grid_feeder.sv
// Directed/randomized bench for grid_feeder against a board-array reference model.
module tb_grid_feeder;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        load_v = 1'b0;
    logic [7:0]  load_d = 8'h00;
    logic        start = 1'b0;
    logic [15:0] move_d = 16'h0000;
    logic        ret_v = 1'b0;
    logic [7:0]  ret_d = 8'h00;
    logic        grid_ov;
    logic [7:0]  grid_od;
    logic        move_ov;
    logic [15:0] move_od;
    logic        busy;
    logic        board_valid;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_board [64];
    logic [7:0] stim_vals [64];

    grid_feeder #(.MOVE_WIDTH(16), .GRID_ELE_WIDTH(8)) dut (
        .clk(clk), .nrst(nrst),
        .load_v(load_v), .load_d(load_d),
        .start(start), .move_d(move_d),
        .ret_v(ret_v), .ret_d(ret_d),
        .grid_ov(grid_ov), .grid_od(grid_od),
        .move_ov(move_ov), .move_od(move_od),
        .busy(busy), .board_valid(board_valid),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b00, grid_ov, grid_od, move_ov, move_od, busy, board_valid, done, err};
    endfunction

    // Host writes squares lo..hi from stim_vals; start is thrown in during gaps once loading.
    task automatic load_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    load_v = 1'b0;
                    start  = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    ret_v  = 1'($urandom_range(0, 1));
                    ret_d  = 8'($urandom);
                    step();
                end
            end
            start  = 1'b0;
            ret_v  = 1'b0;
            load_v = 1'b1;
            load_d = stim_vals[i];
            model_board[i] = stim_vals[i];
            step();
            load_v = 1'b0;
        end
    endtask

    task automatic full_load(input bit gaps);
        load_range(0, 63, gaps);
        chk("load_done", {30'd0, board_valid, busy}, {30'd0, 1'b1, 1'b0});
    endtask

    // Issue start and follow the full board stream plus move beat.
    task automatic send(input logic [15:0] m, input bit noise);
        start  = 1'b1;
        move_d = m;
        step();
        start  = 1'b0;
        move_d = 16'($urandom);
        chk("accept", {30'd0, busy, grid_ov}, {30'd0, 1'b1, 1'b0});
        for (int i = 0; i < 64; i++) begin
            if (noise) begin
                ret_v  = 1'($urandom_range(0, 1));
                ret_d  = 8'($urandom);
                load_v = 1'($urandom_range(0, 1));
                load_d = 8'($urandom);
            end
            step();
            chk($sformatf("grid_beat_%0d", i), {22'd0, move_ov, grid_ov, grid_od},
                {22'd0, 1'b0, 1'b1, model_board[i]});
        end
        ret_v  = 1'b0;
        load_v = 1'b0;
        step();
        chk("move_beat", {6'd0, move_ov, move_od, grid_ov, grid_od},
            {6'd0, 1'b1, m, 1'b0, 8'h00});
    endtask

    // Decoder returns 64 squares with random gaps while load_v/start noise is ignored.
    task automatic recv(input bit all_ff);
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 2)) begin
                ret_v  = 1'b0;
                load_v = 1'($urandom_range(0, 1));
                load_d = 8'($urandom);
                start  = 1'($urandom_range(0, 1));
                step();
            end
            load_v = 1'b0;
            start  = 1'b0;
            ret_v  = 1'b1;
            ret_d  = all_ff ? 8'hFF : 8'($urandom);
            model_board[i] = ret_d;
            step();
            ret_v = 1'b0;
            if (i == 0) begin
                chk("move_quiet", {15'd0, move_ov, move_od}, 32'd0);
            end
            if (i < 63) begin
                chk("recv_busy", {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
            end
        end
        chk("done_pulse", {29'd0, done, busy, board_valid}, {29'd0, 1'b1, 1'b0, 1'b1});
        step();
        chk("done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("reset_outs", all_outs(), 32'd0);
        nrst = 1'b1;
        step();
        chk("idle_outs", all_outs(), 32'd0);

        // Start without a board is rejected.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("noboard_err", {29'd0, err, busy, grid_ov}, {29'd0, 1'b1, 1'b0, 1'b0});
        step();
        chk("noboard_err_clear", all_outs(), 32'd0);

        // Ascending board, then the reference send.
        for (int i = 0; i < 64; i++) stim_vals[i] = 8'(i);
        full_load(1'b0);
        send(16'h1234, 1'b0);
        recv(1'b1);
        send(16'($urandom), 1'b1);
        recv(1'b0);
        send(16'($urandom), 1'b0);
        recv(1'b0);

        // 63 squares with gaps, start must be ignored.
        for (int i = 0; i < 64; i++) stim_vals[i] = 8'($urandom);
        load_range(0, 62, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("partial_start", {28'd0, err, grid_ov, board_valid, busy}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        load_range(63, 63, 1'b0);
        chk("partial_complete", {30'd0, board_valid, busy}, {30'd0, 1'b1, 1'b0});
        send(16'($urandom), 1'b1);
        recv(1'b0);

        // Simultaneous load and start in IDLE with a valid board.
        for (int i = 0; i < 64; i++) stim_vals[i] = 8'($urandom);
        load_v = 1'b1;
        load_d = stim_vals[0];
        model_board[0] = stim_vals[0];
        start  = 1'b1;
        move_d = 16'hBEEF;
        step();
        load_v = 1'b0;
        start  = 1'b0;
        chk("load_wins", {28'd0, err, busy, board_valid, grid_ov}, {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        step();
        chk("load_wins_quiet", {30'd0, err, grid_ov}, 32'd0);
        load_range(1, 63, 1'b1);
        chk("reload_valid", {30'd0, board_valid, busy}, {30'd0, 1'b1, 1'b0});

        // Reset in the middle of a stream.
        start  = 1'b1;
        move_d = 16'h5A5A;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("abort_beat_%0d", i), {23'd0, grid_ov, grid_od}, {23'd0, 1'b1, model_board[i]});
        end
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_err", {28'd0, err, busy, grid_ov, board_valid}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        step();

        // Recovery after a full reload.
        for (int i = 0; i < 64; i++) stim_vals[i] = 8'($urandom);
        full_load(1'b1);
        send(16'($urandom), 1'b0);
        recv(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_feeder.md
GRID_FEEDER -- requirements
Module: grid_feeder

Interface
REQ-001 SHALL have parameter MOVE_WIDTH, default 16, move word width.
REQ-002 SHALL have parameter GRID_ELE_WIDTH, default 8, width of one board square.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, system clock, all logic on rising edge.
REQ-004 nrst input 1, asynchronous active-low reset.
REQ-005 load_v input 1, host board-load strobe, one square per cycle.
REQ-006 load_d input GRID_ELE_WIDTH, host square value.
REQ-007 start input 1, single-cycle request to issue the board plus a move.
REQ-008 move_d input MOVE_WIDTH, move word, sampled only when start is accepted.
REQ-009 ret_v input 1, updated-square strobe from the downstream decoder.
REQ-010 ret_d input GRID_ELE_WIDTH, updated square value.
REQ-011 grid_ov output 1, square-valid strobe to the decoder.
REQ-012 grid_od output GRID_ELE_WIDTH, square value to the decoder.
REQ-013 move_ov output 1, single-cycle move-valid strobe to the decoder.
REQ-014 move_od output MOVE_WIDTH, latched move.
REQ-015 busy output 1, high in every state except IDLE.
REQ-016 board_valid output 1, a complete board is held.
REQ-017 done output 1, single-cycle pulse when the return board has been fully absorbed.
REQ-018 err output 1, single-cycle pulse when start is rejected.

Function
REQ-019 SHALL hold a 64-entry board buffer, index = rank*8 + file, streamed in index order 0..63.
REQ-020 SHALL implement states IDLE, LOAD, SEND_GRID, SEND_MOVE, RECV, with a 6-bit square counter cnt.
REQ-021 IDLE: load_v writes buf[0], sets cnt=1, clears board_valid, and moves to LOAD.
REQ-022 IDLE: start with board_valid=1 and load_v=0 latches move_d, sets cnt=0, and moves to SEND_GRID.
REQ-023 IDLE: start with board_valid=0 pulses err the next cycle and stays in IDLE.
REQ-024 IDLE: load_v and start asserted together: load wins and start is dropped without err.
REQ-025 LOAD: each load_v writes buf[cnt] and increments cnt; cycles without load_v hold the state.
REQ-026 LOAD: the write at cnt=63 sets board_valid=1 and returns to IDLE.
REQ-027 LOAD: start is ignored.
REQ-028 SEND_GRID: grid_ov=1 and grid_od=buf[cnt] on every cycle, with cnt incremented each cycle.
REQ-029 SEND_GRID: no backpressure, so exactly 64 consecutive cycles.
REQ-030 SEND_GRID: after cnt=63 goes to SEND_MOVE.
REQ-031 SEND_MOVE: move_ov=1 for exactly one cycle with move_od equal to the latched move, then goes to RECV with cnt=0.
REQ-032 RECV: each ret_v writes buf[cnt] and increments cnt.
REQ-033 RECV: the write at cnt=63 pulses done the next cycle, keeps board_valid=1, and returns to IDLE.
REQ-034 Latency: start accepted at edge T puts the first grid_ov at cycle T+1, the last at T+64, and move_ov at T+65.
REQ-035 ret_v outside RECV and load_v outside IDLE/LOAD SHALL be ignored, with no buffer change.
REQ-036 grid_od and move_od SHALL be 0 whenever their valid strobe is low.
REQ-037 cnt wrap from 63 to 0 SHALL occur only on a state exit, never inside a state.

Reset
REQ-038 nrst low SHALL immediately force state=IDLE, cnt=0, board_valid=0, the latched move to 0, and all outputs to 0.
REQ-039 Buffer contents need no reset; board_valid=0 marks them invalid.
REQ-040 Reset in any state, including mid-SEND_GRID or mid-RECV, SHALL abort the transfer, and a following start SHALL pulse err until a full reload.

Verification
REQ-041 Load squares 0x00..0x3F, then start with move_d=0x1234 -> 64 grid_ov beats carrying 0x00..0x3F in order, then one move_ov with 0x1234 at T+65.
REQ-042 Start with no prior load -> err pulse one cycle later, busy stays 0, and no grid_ov.
REQ-043 After a send, drive 64 ret_v with 0xFF, then start again -> done pulses after the 64th ret_v and the second stream is all 0xFF.
REQ-044 Load 63 squares with gaps in load_v, then assert start -> start is ignored and board_valid=0; the 64th load sets board_valid=1.
REQ-045 Assert nrst low at the 30th grid_ov beat -> all outputs 0 at once, board_valid=0, and a following start gives err.
REQ-046 Same-cycle load_v and start in IDLE with board_valid=1 -> LOAD is entered, board_valid=0, and no err or grid_ov.
